// File: rtl/config_loader.sv
// config_loader: assembles a framed stream of config words and writes the frame into config_mem.
// Optional write-ack timeout is compiled in when LOADER_TIMEOUT_EN is defined.
module config_loader #(
  parameter int width          = 16,
  parameter int num_inputs     = 8,
  parameter int timeout_cycles = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             run_en,
  output logic             write_en,
  output logic [width-1:0] w_data_out [0:num_inputs],
  input  logic             write_rdy,
  input  logic             write_ack,
  output logic             on_off,
  output logic             load_done,
  output logic             frame_err,
  output logic             timeout_err
);
  // state    | meaning
  // COLLECT  | accepting stream words into the frame buffer
  // WAIT_RDY | frame complete, waiting for config_mem write_rdy
  // WRITE    | write_en asserted, waiting for write_ack
  // RUN      | config_mem in run mode until run_en drops
  localparam logic [1:0] COLLECT  = 2'd0;
  localparam logic [1:0] WAIT_RDY = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;

  localparam int            CW       = $clog2(num_inputs + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(num_inputs);

  if (num_inputs < 1 || timeout_cycles < 1) begin : g_param_check
    $error("config_loader: num_inputs and timeout_cycles must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] data_q [0:num_inputs];
  logic [width-1:0] data_d [0:num_inputs];
  logic             write_en_q, write_en_d;
  logic             on_off_q, on_off_d;
  logic             load_done_q, load_done_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;
  logic             committed_q, committed_d;
  logic             accept;
  logic             expire;

  assign in_ready = reset & (state_q == COLLECT);
  assign accept   = in_valid & in_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign expire = ((state_q == WAIT_RDY) || (state_q == WRITE)) &&
                  (tmo_q == TW'(timeout_cycles - 1));

  always_comb begin
    tmo_d = tmo_q;
    if ((state_q == COLLECT) && (state_d == WAIT_RDY)) begin
      tmo_d = '0;
    end else if ((state_q == WAIT_RDY) || (state_q == WRITE)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    write_en_d  = write_en_q;
    load_done_d = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    committed_d = committed_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          data_d[cnt_q] = in_data;
          if ((cnt_q == CNT_LAST) && in_last) begin
            state_d = WAIT_RDY;
          end else if ((cnt_q == CNT_LAST) || in_last) begin
            // malformed frame: restart from word 0, stale entries stay in place
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_RDY: begin
        if (expire) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = COLLECT;
        end else if (write_rdy) begin
          write_en_d = 1'b1;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (write_ack) begin
          write_en_d  = 1'b0;
          load_done_d = 1'b1;
          cnt_d       = '0;
          committed_d = 1'b1;
          state_d     = run_en ? RUN : COLLECT;
        end else if (expire) begin
          write_en_d = 1'b0;
          timeout_d  = 1'b1;
          cnt_d      = '0;
          state_d    = COLLECT;
        end
      end
      RUN: begin
        if (!run_en) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    // run mode is only allowed when no write is pending
    case (state_d)
      COLLECT: on_off_d = committed_d & run_en;
      RUN:     on_off_d = 1'b1;
      default: on_off_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      write_en_q  <= 1'b0;
      on_off_q    <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      committed_q <= 1'b0;
      for (int i = 0; i <= num_inputs; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_en_q  <= write_en_d;
      on_off_q    <= on_off_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      committed_q <= committed_d;
      data_q      <= data_d;
    end
  end

  assign write_en    = write_en_q;
  assign on_off      = on_off_q;
  assign load_done   = load_done_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_q;
  assign w_data_out  = data_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: stimulus queues expected events, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_config_loader;
  localparam int W = 16;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         run_en = 1'b0;
  logic         write_rdy = 1'b0;
  logic         write_ack = 1'b0;
  logic         in_ready, write_en, on_off, load_done, frame_err, timeout_err;
  logic [W-1:0] w_data_out [0:N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           kind;   // 1 = load_done, 2 = frame_err, 3 = timeout_err
    logic [W-1:0] d0;
    logic [W-1:0] d8;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;
  int   we_run = 0;
  int   we_len_last = 0;
  int   k;

  always #5 clk = ~clk;

  config_loader #(.width(W), .num_inputs(N), .timeout_cycles(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .run_en(run_en), .write_en(write_en), .w_data_out(w_data_out),
    .write_rdy(write_rdy), .write_ack(write_ack), .on_off(on_off),
    .load_done(load_done), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int kind, input logic [W-1:0] d0, input logic [W-1:0] d8);
    exp_t e;
    e.kind = kind;
    e.d0   = d0;
    e.d8   = d8;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [W-1:0] base, input logic [W-1:0] step,
                            input int nwords, input int last_idx);
    for (int i = 0; i < nwords; i++) begin
      in_valid = 1'b1;
      in_data  = base + step * W'(i);
      in_last  = (i == last_idx);
      chk("in_ready_collect", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_we();
    int n = 0;
    while (write_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("write_en_wait", write_en, 1);
  endtask

  task automatic commit_frame();
    wait_we();
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    chk("load_done_pulse", load_done, 1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (write_en) we_run++;
      else if (we_run > 0) begin
        we_len_last = we_run;
        we_run = 0;
      end
      if (write_en) chk("on_off_during_write", on_off, 0);
      if (load_done || frame_err || timeout_err) begin
        mon_kind = load_done ? 1 : (frame_err ? 2 : 3);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", mon_kind, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", mon_kind, mon_e.kind);
          if (mon_e.kind == 1) begin
            chk("frame_word0", w_data_out[0], mon_e.d0);
            chk("frame_word8", w_data_out[N], mon_e.d8);
          end
        end
      end
    end else begin
      we_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_on_off", on_off, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_word0", w_data_out[0], 0);
    chk("rst_word8", w_data_out[N], 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // no run mode before the first commit
    run_en = 1'b1;
    tick();
    chk("on_off_precommit", on_off, 0);
    run_en = 1'b0;

    // basic frame, ack one cycle after write_en
    write_rdy = 1'b1;
    expect_evt(1, 16'h1111, 16'h9999);
    send_frame(16'h1111, 16'h1111, 9, 8);
    chk("in_ready_wait_rdy", in_ready, 0);
    wait_we();
    tick();
    chk("we_hold", write_en, 1);
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    chk("we_fall_at_ack", write_en, 0);
    chk("load_done_t1", load_done, 1);
    chk("in_ready_back", in_ready, 1);
    chk("on_off_no_run", on_off, 0);
    tick();
    chk("we_len_2", we_len_last, 2);

    // early in_last, then a good frame
    expect_evt(2, 0, 0);
    send_frame(16'h0100, 16'h0001, 4, 3);
    chk("frame_err_early", frame_err, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("we_after_ferr", write_en, 0);
    end
    expect_evt(1, 16'hAAAA, 16'hAAB2);
    send_frame(16'hAAAA, 16'h0001, 9, 8);
    commit_frame();

    // write_rdy held low; host words ignored meanwhile
    write_rdy = 1'b0;
    expect_evt(1, 16'h2000, 16'h2088);
    send_frame(16'h2000, 16'h0011, 9, 8);
    for (int i = 0; i < 10; i++) begin
      chk("we_wait_rdy", write_en, 0);
      chk("in_ready_wait_rdy", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    write_rdy = 1'b1;
    tick();
    chk("we_after_rdy", write_en, 1);
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    chk("load_done_t3", load_done, 1);

    // run_en before ack
    expect_evt(1, 16'h3000, 16'h3808);
    send_frame(16'h3000, 16'h0101, 9, 8);
    run_en = 1'b1;
    wait_we();
    chk("on_off_pending", on_off, 0);
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    chk("on_off_at_ack", on_off, 1);
    chk("we_off_run", write_en, 0);
    chk("in_ready_run", in_ready, 0);
    tick();
    chk("on_off_run_hold", on_off, 1);
    chk("in_ready_run_hold", in_ready, 0);
    run_en = 1'b0;
    tick();
    chk("on_off_run_exit", on_off, 0);
    chk("in_ready_run_exit", in_ready, 1);
    run_en = 1'b1;
    tick();
    chk("on_off_follows_collect", on_off, 1);
    run_en = 1'b0;
    tick();
    chk("on_off_drop_collect", on_off, 0);

    // nine words without in_last
    expect_evt(2, 0, 0);
    send_frame(16'h7000, 16'h0001, 9, -1);
    chk("frame_err_nolast", frame_err, 1);
    tick();
    chk("we_after_nolast", write_en, 0);
    chk("in_ready_after_nolast", in_ready, 1);

`ifdef LOADER_TIMEOUT_EN
    expect_evt(3, 0, 0);
    send_frame(16'h4000, 16'h0001, 9, 8);
    k = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("timeout_cycle", k, 16);
    chk("we_after_timeout", write_en, 0);
    chk("on_off_after_timeout", on_off, 0);
    chk("in_ready_after_timeout", in_ready, 1);
`else
    send_frame(16'h4000, 16'h0001, 9, 8);
    wait_we();
    for (int i = 0; i < 20; i++) tick();
    chk("we_waits_forever", write_en, 1);
    chk("timeout_err_tied", timeout_err, 0);
    expect_evt(1, 16'h4000, 16'h4008);
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    chk("load_done_late_ack", load_done, 1);
`endif

    // reset during a pending write
    send_frame(16'h5000, 16'h0001, 9, 8);
    wait_we();
    #2;
    reset = 1'b0;
    #1;
    chk("async_we_drop", write_en, 0);
    chk("async_on_off", on_off, 0);
    chk("async_load_done", load_done, 0);
    chk("async_frame_err", frame_err, 0);
    chk("async_timeout_err", timeout_err, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_word0", w_data_out[0], 0);
    chk("async_word8", w_data_out[N], 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("in_ready_rerelease", in_ready, 1);
    run_en = 1'b1;
    tick();
    chk("on_off_precommit2", on_off, 0);
    run_en = 1'b0;
    expect_evt(1, 16'h6000, 16'h6010);
    send_frame(16'h6000, 16'h0002, 9, 8);
    commit_frame();

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
